// File: rtl/xpb_lut_accum_if.sv
// Bus bundle for xpb_lut_accum: table write port, index beat input and
// sum output handshakes. master = driver of beats/writes, slave = the block.
interface xpb_lut_accum_if #(
  parameter int IDX_W  = 5,
  parameter int WORD_W = 1024,
  parameter int NUM_CH = 4,
  parameter int SUM_W  = WORD_W + $clog2(NUM_CH) + 1
);
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_addr;
  logic [WORD_W-1:0]        wr_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*IDX_W-1:0]  in_idx;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         out_sum;
  logic                     wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_sum, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_sum, wr_err
  );
endinterface

// File: rtl/xpb_lut_accum.sv
// XPB reduction lookup: runtime-loadable table of precomputed multiples,
// NUM_CH lookups per beat, summed through a 2-stage pipeline
// (S1 = looked-up words, S2 = their sum). Entry 0 always reads zero.
// Optional build macro XPB_LOAD_LOCK_EN: table writes are refused while any
// beat is pending or in flight, with a one-cycle wr_err pulse.
module xpb_lut_accum #(
  parameter int IDX_W  = 5,
  parameter int WORD_W = 1024,
  parameter int NUM_CH = 4,
  parameter int SUM_W  = WORD_W + $clog2(NUM_CH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  xpb_lut_accum_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int LVLS  = $clog2(NUM_CH);

  logic [WORD_W-1:0] tbl     [DEPTH];
  logic [WORD_W-1:0] s1_word [NUM_CH];
  logic [SUM_W-1:0]  node    [NUM_CH];
  logic              s1_valid;
  logic              out_valid_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic              adv;
  logic              wr_do;

  // Whole pipeline moves together; a held output freezes both stages.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum  = sum_q;

`ifdef XPB_LOAD_LOCK_EN
  logic wr_block;
  logic wr_err_q;

  assign wr_block   = s1_valid || out_valid_q || bus.in_valid;
  assign wr_do      = bus.wr_en && !wr_block;
  assign bus.wr_err = wr_err_q;

  // Flag a write refused because the table is in use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= bus.wr_en && wr_block;
  end
`else
  assign wr_do      = bus.wr_en;
  assign bus.wr_err = 1'b0;
`endif

  // Table storage; entry 0 is never written so it stays at its reset zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_do && (bus.wr_addr != '0)) begin
      tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  // S1: register the looked-up words; a same-edge write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) s1_word[c] <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        for (int c = 0; c < NUM_CH; c++)
          s1_word[c] <= tbl[bus.in_idx[c*IDX_W +: IDX_W]];
      end
    end
  end

  // Balanced adder tree, reduced in place: level l folds node[i+2^l] into node[i].
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) node[c] = SUM_W'(s1_word[c]);
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (((i % (2 << l)) == 0) && ((i + (1 << l)) < NUM_CH))
          node[i] = node[i] + node[i + (1 << l)];
      end
    end
    sum_d = node[0];
  end

  // S2: register the sum and the output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) sum_q <= sum_d;
    end
  end
endmodule

// File: tb/tb_xpb_lut_accum.sv
// Directed self-checking bench for xpb_lut_accum (default parameters).
module tb_xpb_lut_accum;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 1024;
  localparam int NUM_CH = 4;
  localparam int SUM_W  = WORD_W + $clog2(NUM_CH) + 1;

`ifdef XPB_LOAD_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  xpb_lut_accum_if #(.IDX_W(IDX_W), .WORD_W(WORD_W), .NUM_CH(NUM_CH), .SUM_W(SUM_W)) bus ();

  xpb_lut_accum #(.IDX_W(IDX_W), .WORD_W(WORD_W), .NUM_CH(NUM_CH), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IDX_W-1:0] a, input logic [WORD_W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  function automatic logic [NUM_CH*IDX_W-1:0] pack(input int c3, input int c2, input int c1, input int c0);
    return {IDX_W'(c3), IDX_W'(c2), IDX_W'(c1), IDX_W'(c0)};
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++;
    if (bus.out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %0h exp 0", bus.out_sum); end
    checks++;
    if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %0b exp 0", bus.wr_err); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    do_write(5'd1, WORD_W'(32'h5));
    do_write(5'd2, WORD_W'(32'h7));
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(0, 0, 2, 1);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", bus.out_valid); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", bus.out_valid); end
    checks++;
    if (bus.out_sum !== SUM_W'(32'hC)) begin errors++; $display("FAIL basic_sum got %0h exp c", bus.out_sum); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_entry0();
    do_write(5'd0, WORD_W'(32'hFF));
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL entry0_valid got %0b exp 1", bus.out_valid); end
    checks++;
    if (bus.out_sum !== '0) begin errors++; $display("FAIL entry0_sum got %0h exp 0", bus.out_sum); end
    tick();
  endtask

  task automatic test_max();
    logic [SUM_W-1:0] exp_sum;
    exp_sum = {{(SUM_W-WORD_W){1'b0}}, {WORD_W{1'b1}}} << 2;
    do_write(5'd31, {WORD_W{1'b1}});
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(31, 31, 31, 31);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_sum !== exp_sum) begin errors++; $display("FAIL max_sum got %0h exp %0h", bus.out_sum, exp_sum); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SUM_W-1:0] got[$];
    int k;
    for (int i = 1; i <= 8; i++) do_write(IDX_W'(i), WORD_W'(i));
    k = 1;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid  = (k <= 8);
      bus.in_idx    = pack(0, 0, 0, k);
      #1;
      if (!bus.out_ready && bus.out_valid) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %0b exp 0", cyc, bus.in_ready); end
      end
      if (bus.in_valid && bus.in_ready) k++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_sum);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL stream_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] !== SUM_W'(i + 1)) begin errors++; $display("FAIL stream_val[%0d] got %0h exp %0h", i, got[i], i + 1); end
    end
    tick();
  endtask

  task automatic test_collision();
    do_write(5'd3, WORD_W'(32'h1));
    tick();
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd3;
    bus.wr_data  = WORD_W'(32'h9);
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(0, 0, 0, 3);
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.wr_err !== LOCK) begin errors++; $display("FAIL coll_wr_err got %0b exp %0b", bus.wr_err, LOCK); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL coll_wr_err_pulse got %0b exp 0", bus.wr_err); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== SUM_W'(32'h1))
      begin errors++; $display("FAIL coll_first got v=%0b sum=%0h exp v=1 sum=1", bus.out_valid, bus.out_sum); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== (LOCK ? SUM_W'(32'h1) : SUM_W'(32'h9)))
      begin errors++; $display("FAIL coll_second got v=%0b sum=%0h exp v=1 sum=%0h", bus.out_valid, bus.out_sum, LOCK ? 1 : 9); end
    tick();
  endtask

  task automatic test_reset_midflight();
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(0, 0, 0, 3);
    tick();
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b exp 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0b exp 0", bus.out_valid); end
    checks++;
    if (bus.out_sum !== '0) begin errors++; $display("FAIL mid_async_sum got %0h exp 0", bus.out_sum); end
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid[%0d] got %0b exp 0", i, bus.out_valid); end
    end
    bus.in_valid = 1'b1;
    bus.in_idx   = pack(31, 3, 2, 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== '0)
      begin errors++; $display("FAIL mid_table_cleared got v=%0b sum=%0h exp v=1 sum=0", bus.out_valid, bus.out_sum); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_entry0();
    test_max();
    test_back_to_back();
    test_collision();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
